// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU between two requesters.
// One operation in flight at a time; the result is returned tagged with the requester id.
module alu_sched #(
    parameter int PART_LEN = 8,
    parameter int LAT      = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_op0,
    input  logic [1:0]              req_op1,
    input  logic [2*PART_LEN-1:0]   req_a0,
    input  logic [2*PART_LEN-1:0]   req_b0,
    input  logic [2*PART_LEN-1:0]   req_a1,
    input  logic [2*PART_LEN-1:0]   req_b1,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic [2*PART_LEN-1:0]   resp_data,
    output logic [2*PART_LEN-1:0]   alu_a,
    output logic [2*PART_LEN-1:0]   alu_b,
    output logic [1:0]              alu_ctrl,
    input  logic [2*PART_LEN-1:0]   alu_res,
    output logic                    busy,
    output logic [15:0]             ops_done
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant_id;
    logic             any_req;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

    assign any_req   = |req_valid;
    assign req_ready = (state == IDLE && any_req) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_a      <= grant_id ? req_a1  : req_a0;
                        alu_b      <= grant_id ? req_b1  : req_b0;
                        alu_ctrl   <= grant_id ? req_op1 : req_op0;
                        resp_id    <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CNT_LOAD;
                        state      <= EXEC;
                    end
                end
                // ALU inputs held stable for exactly LAT cycles.
                EXEC: begin
                    if (cnt == '0) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CAPT: begin
                    resp_data  <= alu_res;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ops_done   <= ops_done + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched against a transaction-level model of
// grant order, result value, latency and completion count.
module tb_alu_sched;

    localparam int PART_LEN = 8;
    localparam int LAT      = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0, req_op1;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resp_data;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_ctrl;
    logic [15:0] alu_res;
    logic        busy;
    logic [15:0] ops_done;

    int n_chk  = 0;
    int n_fail = 0;

    logic        exp_last;
    logic [15:0] exp_ops;

    alu_sched #(.PART_LEN(PART_LEN), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // ALU stand-in: sum of the operands, delivered LAT edges after sampling.
    logic [15:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_a + alu_b;
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_res = alu_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request pattern from the current negedge and follow it to completion.
    task automatic run_txn(input logic [1:0] vld, input logic [1:0] op0, input logic [1:0] op1,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1, input int stall);
        logic        g;
        logic [15:0] ea, eb, esum;
        logic [1:0]  eop;
        int          lat;
        g    = (vld == 2'b01) ? 1'b0 : (vld == 2'b10) ? 1'b1 : ~exp_last;
        ea   = g ? a1 : a0;
        eb   = g ? b1 : b0;
        eop  = g ? op1 : op0;
        esum = ea + eb;

        req_op0 = op0; req_op1 = op1;
        req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        req_valid  = vld;
        resp_ready = (stall == 0);
        #1;
        chk("req_ready_grant", req_ready, g ? 2'b10 : 2'b01);
        chk("busy_idle", busy, 1'b0);
        @(posedge clk);
        exp_last = g;

        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_ctrl", alu_ctrl, eop);
        chk("busy_exec", busy, 1'b1);
        chk("req_ready_exec", req_ready, 2'b00);

        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_latency", lat, LAT + 2);
        if (stall == 0) req_valid = 2'b00;
        #1;
        chk("resp_data", resp_data, esum);
        chk("resp_id", resp_id, g);
        chk("ops_before_hs", ops_done, exp_ops);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", resp_valid, 1'b1);
            chk("stall_data", resp_data, esum);
            chk("stall_id", resp_id, g);
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_ops", ops_done, exp_ops);
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk);
        exp_ops = exp_ops + 16'd1;
        @(negedge clk);
        chk("resp_valid_clr", resp_valid, 1'b0);
        chk("ops_done", ops_done, exp_ops);
        chk("busy_done", busy, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 2'b00; resp_ready = 1'b0;
        req_op0 = 2'b00; req_op1 = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        exp_last = 1'b1;
        exp_ops  = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_ops", ops_done, 16'd0);
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_req_ready", req_ready, 2'b00);
        rstn = 1'b1;
        @(negedge clk);

        // Ties after reset alternate starting with requester 0.
        run_txn(2'b11, 2'b00, 2'b01, 16'h0001, 16'h0001, 16'h0100, 16'h0200, 0);
        run_txn(2'b11, 2'b00, 2'b01, 16'h0001, 16'h0001, 16'h0100, 16'h0200, 0);
        run_txn(2'b11, 2'b00, 2'b01, 16'h0001, 16'h0001, 16'h0100, 16'h0200, 0);
        run_txn(2'b01, 2'b11, 2'b00, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 0);
        run_txn(2'b10, 2'b00, 2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h0002, 10);

        // Reset while the operation is executing.
        req_a0 = 16'h00AA; req_b0 = 16'h0055; req_op0 = 2'b01;
        req_valid = 2'b01; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", resp_valid, 1'b0);
        chk("mid_rst_alu_a", alu_a, 16'd0);
        chk("mid_rst_ctrl", alu_ctrl, 2'b00);
        chk("mid_rst_data", resp_data, 16'd0);
        chk("mid_rst_id", resp_id, 1'b0);
        chk("mid_rst_ops", ops_done, 16'd0);
        exp_last = 1'b1;
        exp_ops  = 16'd0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_resp", resp_valid, 1'b0);
        end
        run_txn(2'b11, 2'b10, 2'b01, 16'h0010, 16'h0020, 16'h0300, 16'h0400, 0);

        for (int k = 0; k < 200; k++) begin
            run_txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
